// File: rtl/fifo_mem_pkg.sv
// fifo_mem_pkg: shared sizing helpers and the output-buffer state type for
// the fifo_mem_ctrl slice.
//   MEM_WORDS(depth) : number of words in a sync_mem of address width depth
//   CNT_W(depth)     : width of the total-occupancy count (memory + 2)
//   buf_state_t      : output-buffer occupancy, doubles as its FSM state
package fifo_mem_pkg;

    function automatic int MEM_WORDS(input int depth);
        return 1 << depth;
    endfunction

    function automatic int CNT_W(input int depth);
        return depth + 2;
    endfunction

    // Encoding equals the number of held words, so it can be used as a count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/fifo_out_buf.sv
// fifo_out_buf: 2-entry FIFO-ordered output buffer that absorbs the one-cycle
// read latency of sync_mem.
// Ports:
//   clock, resetN : clock and asynchronous active-low reset
//   capture       : write captureData to the tail this edge
//   captureData   : word returning from memory
//   pop           : advance the head this edge (ignored when empty)
//   headValid     : head word present
//   headData      : head word (0 after reset)
//   occupancy     : FSM state, equal to number of words held
module fifo_out_buf
    import fifo_mem_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             capture,
    input  logic [WIDTH-1:0] captureData,
    input  logic             pop,
    output logic             headValid,
    output logic [WIDTH-1:0] headData,
    output buf_state_t       occupancy
);

    logic [WIDTH-1:0] tailData;

    assign headValid = (occupancy != EMPTY);

    // The controller never captures into a full buffer without a pop in the
    // same cycle, so TWO only has to handle the pop cases.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            occupancy <= EMPTY;
            headData  <= '0;
            tailData  <= '0;
        end else begin
            case (occupancy)
                EMPTY: begin
                    if (capture) begin
                        headData  <= captureData;
                        occupancy <= ONE;
                    end
                end
                ONE: begin
                    if (capture && pop) begin
                        headData <= captureData;
                    end else if (capture) begin
                        tailData  <= captureData;
                        occupancy <= TWO;
                    end else if (pop) begin
                        occupancy <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        headData <= tailData;
                        if (capture) tailData  <= captureData;
                        else         occupancy <= ONE;
                    end
                end
                default: occupancy <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/sync_mem.sv
// sync_mem: 2-port synchronous memory, 2**DEPTH words of WIDTH bits.
// Each port writes when writeEnable is high, otherwise it reads; read data
// is registered and valid the cycle after the address edge. No reset on
// contents.
// Ports (per port n = 0/1):
//   clock         : rising-edge clock
//   writeEnableN  : write strobe
//   writeDataN    : write data
//   addressN      : word address
//   readDataN     : registered read data
module sync_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             writeEnable0,
    input  logic [WIDTH-1:0] writeData0,
    input  logic [DEPTH-1:0] address0,
    output logic [WIDTH-1:0] readData0,
    input  logic             writeEnable1,
    input  logic [WIDTH-1:0] writeData1,
    input  logic [DEPTH-1:0] address1,
    output logic [WIDTH-1:0] readData1
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clock) begin
        if (writeEnable0) mem[address0] <= writeData0;
        else              readData0     <= mem[address0];
        if (writeEnable1) mem[address1] <= writeData1;
        else              readData1     <= mem[address1];
    end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// fifo_mem_ctrl: first-word-fall-through valid/ready FIFO built on sync_mem.
// Port 0 of the memory is write-only, port 1 read-only. A 2-entry output
// buffer hides the 1-cycle read latency, giving one word per cycle.
// Optional feature: define FIFO_ALMOST_FULL_EN to add the registered
// almostFull output (memCount >= ALMOST_FULL_LVL).
// Ports:
//   clock, resetN              : clock, asynchronous active-low reset
//   pushValid/pushReady/pushData : upstream stream
//   popValid/popReady/popData    : downstream stream (head word)
//   count                      : total words held (memory + in flight + buffer)
//   memWriteEnable0/memWriteData0/memAddress0 : sync_mem write port
//   memWriteEnable1/memWriteData1/memAddress1 : sync_mem read port controls
//   memReadData1               : sync_mem registered read data
//   almostFull                 : (FIFO_ALMOST_FULL_EN only)
// Handshake: a word moves on a rising edge where valid and ready are both
// high; valid never depends on ready, and ready is low throughout reset.
module fifo_mem_ctrl
    import fifo_mem_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int WIDTH           = 4,
    parameter int ALMOST_FULL_LVL = 2**DEPTH - 2
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      pushValid,
    output logic                      pushReady,
    input  logic [WIDTH-1:0]          pushData,
    output logic                      popValid,
    input  logic                      popReady,
    output logic [WIDTH-1:0]          popData,
    output logic [CNT_W(DEPTH)-1:0]   count,
    output logic                      memWriteEnable0,
    output logic [WIDTH-1:0]          memWriteData0,
    output logic [DEPTH-1:0]          memAddress0,
    output logic                      memWriteEnable1,
    output logic [WIDTH-1:0]          memWriteData1,
    output logic [DEPTH-1:0]          memAddress1,
    input  logic [WIDTH-1:0]          memReadData1
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                      almostFull
`endif
);

    localparam int CW = CNT_W(DEPTH);
    localparam logic [DEPTH:0] MEM_FULL = (DEPTH+1)'(MEM_WORDS(DEPTH));

    logic [DEPTH-1:0] wrPtr;
    logic [DEPTH-1:0] rdPtr;
    logic [DEPTH:0]   memCount;      // one extra bit separates full from empty
    logic             inFlight;      // a read issued last cycle returns now
    logic             outOfReset;    // holds pushReady low until the first edge after reset
    buf_state_t       bufState;
    logic [1:0]       outCount;
    logic             pushFire;
    logic             popFire;
    logic             issue;
    logic [2:0]       slotsUsed;
    logic [DEPTH:0]   memCountNext;
    logic [1:0]       outCountNext;

    assign outCount  = bufState;
    assign pushReady = outOfReset && (memCount != MEM_FULL);
    assign pushFire  = pushValid && pushReady;
    assign popFire   = popValid && popReady;

    // Buffer slots already committed, crediting a pop happening this cycle,
    // so a full buffer being popped still issues and streaming has no bubble.
    assign slotsUsed = {1'b0, outCount} + {2'b0, inFlight} - {2'b0, popFire};
    assign issue     = (memCount != '0) && (slotsUsed < 3'd2);

    assign memCountNext = memCount + (DEPTH+1)'(pushFire) - (DEPTH+1)'(issue);
    assign outCountNext = outCount + {1'b0, inFlight} - {1'b0, popFire};

    assign memWriteEnable0 = pushFire;
    assign memAddress0     = wrPtr;
    assign memWriteData0   = pushData;
    assign memWriteEnable1 = 1'b0;
    assign memWriteData1   = '0;
    assign memAddress1     = rdPtr;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            memCount   <= '0;
            inFlight   <= 1'b0;
            outOfReset <= 1'b0;
            count      <= '0;
        end else begin
            outOfReset <= 1'b1;
            if (pushFire) wrPtr <= wrPtr + 1'b1;
            if (issue)    rdPtr <= rdPtr + 1'b1;
            memCount <= memCountNext;
            inFlight <= issue;
            count    <= CW'(memCountNext) + CW'(issue) + CW'(outCountNext);
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    // Registered from the current memCount: rises the edge after the
    // threshold is reached.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) almostFull <= 1'b0;
        else         almostFull <= (memCount >= (DEPTH+1)'(ALMOST_FULL_LVL));
    end
`endif

    fifo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clock       (clock),
        .resetN      (resetN),
        .capture     (inFlight),
        .captureData (memReadData1),
        .pop         (popFire),
        .headValid   (popValid),
        .headData    (popData),
        .occupancy   (bufState)
    );

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
module tb_fifo_mem_ctrl;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;

    logic             clock;
    logic             resetN;
    logic             pushValid;
    logic             pushReady;
    logic [WIDTH-1:0] pushData;
    logic             popValid;
    logic             popReady;
    logic [WIDTH-1:0] popData;
    logic [DEPTH+1:0] count;
    logic             memWriteEnable0;
    logic [WIDTH-1:0] memWriteData0;
    logic [DEPTH-1:0] memAddress0;
    logic             memWriteEnable1;
    logic [WIDTH-1:0] memWriteData1;
    logic [DEPTH-1:0] memAddress1;
    logic [WIDTH-1:0] memReadData0;
    logic [WIDTH-1:0] memReadData1;
`ifdef FIFO_ALMOST_FULL_EN
    logic             almostFull;
`endif

    int errors = 0;
    int checks = 0;

    fifo_mem_ctrl #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .pushValid       (pushValid),
        .pushReady       (pushReady),
        .pushData        (pushData),
        .popValid        (popValid),
        .popReady        (popReady),
        .popData         (popData),
        .count           (count),
        .memWriteEnable0 (memWriteEnable0),
        .memWriteData0   (memWriteData0),
        .memAddress0     (memAddress0),
        .memWriteEnable1 (memWriteEnable1),
        .memWriteData1   (memWriteData1),
        .memAddress1     (memAddress1),
        .memReadData1    (memReadData1)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almostFull      (almostFull)
`endif
    );

    sync_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock        (clock),
        .writeEnable0 (memWriteEnable0),
        .writeData0   (memWriteData0),
        .address0     (memAddress0),
        .readData0    (memReadData0),
        .writeEnable1 (memWriteEnable1),
        .writeData1   (memWriteData1),
        .address1     (memAddress1),
        .readData1    (memReadData1)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetN    = 1'b0;
        pushValid = 1'b0;
        pushData  = '0;
        popReady  = 1'b0;
        step();
        step();
        checks++; if (popValid !== 1'b0) begin errors++; $display("FAIL reset_popValid: got %0b expected 0", popValid); end
        checks++; if (popData !== 4'h0) begin errors++; $display("FAIL reset_popData: got %0h expected 0", popData); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (pushReady !== 1'b0) begin errors++; $display("FAIL reset_pushReady: got %0b expected 0", pushReady); end
        checks++; if (memWriteEnable1 !== 1'b0) begin errors++; $display("FAIL reset_we1: got %0b expected 0", memWriteEnable1); end
        resetN = 1'b1;
        #1;
        checks++; if (pushReady !== 1'b0) begin errors++; $display("FAIL release_pushReady_before_edge: got %0b expected 0", pushReady); end
        step();
        checks++; if (pushReady !== 1'b1) begin errors++; $display("FAIL release_pushReady_after_edge: got %0b expected 1", pushReady); end
    endtask

    task automatic test_single_word();
        pushValid = 1'b1;
        pushData  = 4'hA;
        #1;
        checks++; if (memWriteEnable0 !== 1'b1) begin errors++; $display("FAIL single_we0: got %0b expected 1", memWriteEnable0); end
        checks++; if (memAddress0 !== 4'd0) begin errors++; $display("FAIL single_addr0: got %0d expected 0", memAddress0); end
        checks++; if (memWriteData0 !== 4'hA) begin errors++; $display("FAIL single_wdata0: got %0h expected a", memWriteData0); end
        step();  // edge 1
        pushValid = 1'b0;
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL single_count_e1: got %0d expected 1", count); end
        checks++; if (popValid !== 1'b0) begin errors++; $display("FAIL single_popValid_e1: got %0b expected 0", popValid); end
        step();  // edge 2
        checks++; if (popValid !== 1'b0) begin errors++; $display("FAIL single_popValid_e2: got %0b expected 0", popValid); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL single_count_e2: got %0d expected 1", count); end
        step();  // edge 3
        checks++; if (popValid !== 1'b1) begin errors++; $display("FAIL single_popValid_e3: got %0b expected 1", popValid); end
        checks++; if (popData !== 4'hA) begin errors++; $display("FAIL single_popData_e3: got %0h expected a", popData); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL single_count_e3: got %0d expected 1", count); end
        popReady = 1'b1;
        step();
        popReady = 1'b0;
        checks++; if (popValid !== 1'b0) begin errors++; $display("FAIL single_popValid_after_pop: got %0b expected 0", popValid); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
    endtask

    // Push 0..15 on edges 1..16; word k must be at the head after edge 3+k.
    task automatic test_streaming();
        popReady = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            pushValid = (c <= 16);
            pushData  = 4'(c - 1);
            #1;
            if (c <= 16) begin
                checks++; if (pushReady !== 1'b1) begin errors++; $display("FAIL stream_pushReady c=%0d: got %0b expected 1", c, pushReady); end
            end
            if (c >= 4 && c <= 19) begin
                checks++;
                if (popValid !== 1'b1 || popData !== 4'(c - 4)) begin
                    errors++;
                    $display("FAIL stream_head c=%0d: got valid=%0b data=%0h expected valid=1 data=%0h", c, popValid, popData, 4'(c - 4));
                end
            end else begin
                checks++; if (popValid !== 1'b0) begin errors++; $display("FAIL stream_idle c=%0d: got valid=%0b expected 0", c, popValid); end
            end
            step();
        end
        pushValid = 1'b0;
        popReady  = 1'b0;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL stream_count_end: got %0d expected 0", count); end
    endtask

    task automatic test_fill();
        int accepted;
        int got;
        bit reopened;
        accepted  = 0;
        popReady  = 1'b0;
        pushValid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            pushData = 4'(accepted);
            #1;
            if (!pushReady) break;
            accepted++;
            step();
        end
        checks++; if (accepted != 18) begin errors++; $display("FAIL fill_accepted: got %0d expected 18", accepted); end
        checks++; if (count !== 6'd18) begin errors++; $display("FAIL fill_count: got %0d expected 18", count); end
        checks++; if (pushReady !== 1'b0) begin errors++; $display("FAIL fill_pushReady: got %0b expected 0", pushReady); end
        checks++; if (memWriteEnable0 !== 1'b0) begin errors++; $display("FAIL fill_we0_when_full: got %0b expected 0", memWriteEnable0); end
        step();
        pushValid = 1'b0;
        checks++; if (count !== 6'd18) begin errors++; $display("FAIL fill_count_hold: got %0d expected 18", count); end
        checks++;
        if (popValid !== 1'b1 || popData !== 4'h0) begin
            errors++;
            $display("FAIL fill_head: got valid=%0b data=%0h expected valid=1 data=0", popValid, popData);
        end
        popReady = 1'b1;
        step();
        popReady = 1'b0;
        reopened = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (pushReady) begin
                reopened = 1'b1;
                break;
            end
            step();
        end
        checks++; if (reopened !== 1'b1) begin errors++; $display("FAIL fill_reopen: got pushReady=%0b expected 1 within 2 cycles", pushReady); end
        got      = 0;
        popReady = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 17; cyc++) begin
            if (popValid) begin
                checks++; if (popData !== 4'(got + 1)) begin errors++; $display("FAIL fill_drain_order #%0d: got %0h expected %0h", got, popData, 4'(got + 1)); end
                got++;
            end
            step();
        end
        popReady = 1'b0;
        checks++; if (got != 17) begin errors++; $display("FAIL fill_drain_total: got %0d expected 17", got); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL fill_count_end: got %0d expected 0", count); end
    endtask

    // 40 pushes with random pop pressure; pointers wrap more than twice.
    task automatic test_wrap();
        logic [WIDTH-1:0] exp_q[$];
        int pushed;
        int popped;
        int maxc;
        pushed = 0;
        popped = 0;
        maxc   = 0;
        for (int cyc = 0; cyc < 400 && popped < 40; cyc++) begin
            pushValid = (pushed < 40);
            pushData  = 4'(pushed * 3 + 1);
            popReady  = (pushed >= 40) ? 1'b1 : 1'(  $urandom_range(0, 1));
            #1;
            if (pushValid && pushReady) begin
                exp_q.push_back(pushData);
                pushed++;
            end
            if (popValid && popReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_underflow: got data=%0h expected no word", popData);
                end else begin
                    if (popData !== exp_q[0]) begin
                        errors++;
                        $display("FAIL wrap_order #%0d: got %0h expected %0h", popped, popData, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                popped++;
            end
            step();
            if (int'(count) > maxc) maxc = int'(count);
            checks++; if (int'(count) != pushed - popped) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", count, pushed - popped); end
        end
        pushValid = 1'b0;
        popReady  = 1'b0;
        checks++; if (popped != 40) begin errors++; $display("FAIL wrap_total: got %0d expected 40", popped); end
        checks++; if (maxc > 18) begin errors++; $display("FAIL wrap_max_count: got %0d expected <= 18", maxc); end
    endtask

`ifdef FIFO_ALMOST_FULL_EN
    task automatic test_almost_full();
        popReady  = 1'b0;
        pushValid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pushData = 4'(i);
            step();
        end
        pushValid = 1'b0;
        checks++; if (almostFull !== 1'b0) begin errors++; $display("FAIL af_before: got %0b expected 0", almostFull); end
        step();
        checks++; if (almostFull !== 1'b1) begin errors++; $display("FAIL af_set: got %0b expected 1", almostFull); end
        popReady = 1'b1;
        step();
        popReady = 1'b0;
        checks++; if (almostFull !== 1'b1) begin errors++; $display("FAIL af_hold: got %0b expected 1", almostFull); end
        step();
        checks++; if (almostFull !== 1'b0) begin errors++; $display("FAIL af_clear: got %0b expected 0", almostFull); end
        popReady = 1'b1;
        for (int cyc = 0; cyc < 60 && count != 0; cyc++) step();
        popReady = 1'b0;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL af_drain: got %0d expected 0", count); end
    endtask
`endif

    task automatic test_reset_mid();
        bit seen;
        popReady  = 1'b0;
        pushValid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            pushData = 4'(i + 8);
            step();
        end
        pushValid = 1'b0;
        checks++; if (count !== 6'd7) begin errors++; $display("FAIL mid_count_before: got %0d expected 7", count); end
        checks++; if (popValid !== 1'b1) begin errors++; $display("FAIL mid_popValid_before: got %0b expected 1", popValid); end
        resetN = 1'b0;
        #1;
        checks++; if (popValid !== 1'b0) begin errors++; $display("FAIL mid_popValid_reset: got %0b expected 0", popValid); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL mid_count_reset: got %0d expected 0", count); end
        checks++; if (pushReady !== 1'b0) begin errors++; $display("FAIL mid_pushReady_reset: got %0b expected 0", pushReady); end
        step();
        resetN = 1'b1;
        step();
        pushValid = 1'b1;
        pushData  = 4'h5;
        #1;
        checks++; if (pushReady !== 1'b1) begin errors++; $display("FAIL mid_pushReady_release: got %0b expected 1", pushReady); end
        step();
        pushValid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (popValid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mid_popValid_timeout: got 0 expected 1 within 10 cycles"); end
        checks++; if (popData !== 4'h5) begin errors++; $display("FAIL mid_first_pop: got %0h expected 5", popData); end
        popReady = 1'b1;
        step();
        popReady = 1'b0;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL mid_count_end: got %0d expected 0", count); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_fill();
        test_wrap();
`ifdef FIFO_ALMOST_FULL_EN
        test_almost_full();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
